// File: rtl/spike_synapse.sv
// spike_synapse: converts an upstream 1-bit spike train into an 8-bit decaying
// synaptic current for the next neuron. Each arriving spike adds (excitatory)
// or subtracts (inhibitory) WEIGHT from the current after a shift-based decay.
// Optional feature macro: SYN_DELAY_EN -- when defined, a DELAY_DEPTH-stage
// axonal delay line sits between spike_in and the integrator, tapped by DELAY.
module spike_synapse #(
   parameter int DELAY_DEPTH = 16
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       spike_in,
   input  logic       enable,
   input  logic [7:0] WEIGHT,
   input  logic       INHIBIT,
   input  logic [2:0] DECAY_SHIFT,
   input  logic [3:0] DELAY,
   output logic [7:0] current,
   output logic       arrived,
   output logic       saturated,
   output logic [7:0] spike_count
);

   // Bit 8 of the result flags that the value was clamped.
   function automatic logic [8:0] add_sat(input logic [7:0] a, input logic [7:0] b);
      logic [8:0] sum;
      sum = {1'b0, a} + {1'b0, b};
      if (sum[8]) begin
         add_sat = {1'b1, 8'hFF};
      end else begin
         add_sat = {1'b0, sum[7:0]};
      end
   endfunction

   function automatic logic [8:0] sub_sat(input logic [7:0] a, input logic [7:0] b);
      if (a < b) begin
         sub_sat = {1'b1, 8'h00};
      end else begin
         sub_sat = {1'b0, a - b};
      end
   endfunction

   logic arrival;

`ifdef SYN_DELAY_EN
   logic [DELAY_DEPTH-1:0] dline_q, dline_d;
   int tap;

   // Shift spike_in into the delay line and select the arrival tap.
   always_comb begin
      dline_d    = dline_q;
      dline_d[0] = spike_in;
      for (int i = 1; i < DELAY_DEPTH; i++) begin
         dline_d[i] = dline_q[i-1];
      end
      if (int'(DELAY) >= DELAY_DEPTH) begin
         tap = DELAY_DEPTH - 1;
      end else begin
         tap = int'(DELAY);
      end
      arrival = 1'b0;
      for (int i = 0; i < DELAY_DEPTH; i++) begin
         if (i == tap) begin
            arrival = dline_q[i];
         end
      end
   end

   // Delay line keeps shifting regardless of enable; reset clears every stage.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         dline_q <= '0;
      end else begin
         dline_q <= dline_d;
      end
   end
`else
   logic [3:0] unused_delay;
   assign unused_delay = DELAY ^ 4'(DELAY_DEPTH);
   assign arrival = spike_in;
`endif

   logic [7:0] current_q, current_d;
   logic       arrived_q, arrived_d;
   logic       saturated_q, saturated_d;
   logic [7:0] count_q, count_d;
   logic [7:0] dec_amt;
   logic [7:0] decayed;
   logic [8:0] integ;

   // Decay the current, then integrate any arriving spike with clamping.
   always_comb begin
      dec_amt = current_q >> DECAY_SHIFT;
      if (dec_amt == 8'd0 && current_q != 8'd0) begin
         dec_amt = 8'd1;
      end
      decayed = current_q - dec_amt;
      if (INHIBIT) begin
         integ = sub_sat(decayed, WEIGHT);
      end else begin
         integ = add_sat(decayed, WEIGHT);
      end

      current_d   = current_q;
      arrived_d   = 1'b0;
      saturated_d = 1'b0;
      count_d     = count_q;
      if (enable) begin
         arrived_d = arrival;
         if (arrival) begin
            current_d   = integ[7:0];
            saturated_d = integ[8];
            if (count_q != 8'hFF) begin
               count_d = count_q + 8'd1;
            end
         end else begin
            current_d = decayed;
         end
      end
   end

   // State registers; reset wins over any same-edge arrival.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         current_q   <= 8'd0;
         arrived_q   <= 1'b0;
         saturated_q <= 1'b0;
         count_q     <= 8'd0;
      end else begin
         current_q   <= current_d;
         arrived_q   <= arrived_d;
         saturated_q <= saturated_d;
         count_q     <= count_d;
      end
   end

   assign current     = current_q;
   assign arrived     = arrived_q;
   assign saturated   = saturated_q;
   assign spike_count = count_q;

endmodule

// File: tb/tb_spike_synapse.sv
// Testbench for spike_synapse: directed scenarios plus randomized traffic,
// every cycle compared against a spike-history reference model.
module tb_spike_synapse;

   localparam int DD = 16;
`ifdef SYN_DELAY_EN
   localparam int LAT0 = 1;
`else
   localparam int LAT0 = 0;
`endif

   logic       clk;
   logic       rst_n;
   logic       spike_in;
   logic       enable;
   logic [7:0] WEIGHT;
   logic       INHIBIT;
   logic [2:0] DECAY_SHIFT;
   logic [3:0] DELAY;
   logic [7:0] current;
   logic       arrived;
   logic       saturated;
   logic [7:0] spike_count;

   spike_synapse #(.DELAY_DEPTH(DD)) dut (
      .clk(clk), .rst_n(rst_n), .spike_in(spike_in), .enable(enable),
      .WEIGHT(WEIGHT), .INHIBIT(INHIBIT), .DECAY_SHIFT(DECAY_SHIFT), .DELAY(DELAY),
      .current(current), .arrived(arrived), .saturated(saturated), .spike_count(spike_count)
   );

   always #5 clk = ~clk;

   int n_asrt = 0;
   int n_fail = 0;

   // reference model state
   int m_cur = 0, m_cnt = 0, m_arr = 0, m_sat = 0;
   bit hist[$];   // hist[0] = spike sampled on the previous edge

   // per-step observation log
   int log_cur[$], log_arr[$], log_sat[$], log_cnt[$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_asrt++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic step();
      bit a;
      int eff, d, dec, s;
`ifdef SYN_DELAY_EN
      eff = (int'(DELAY) >= DD) ? DD - 1 : int'(DELAY);
      a = (hist.size() > eff) ? hist[eff] : 1'b0;
`else
      eff = 0;
      a = spike_in;
`endif
      if (!rst_n) begin
         m_cur = 0; m_cnt = 0; m_arr = 0; m_sat = 0;
         hist.delete();
      end else begin
         if (enable) begin
            d = m_cur >> DECAY_SHIFT;
            if (d == 0 && m_cur != 0) d = 1;
            dec = m_cur - d;
            m_sat = 0;
            if (a) begin
               if (INHIBIT) begin
                  if (dec < int'(WEIGHT)) begin m_cur = 0; m_sat = 1; end
                  else m_cur = dec - int'(WEIGHT);
               end else begin
                  s = dec + int'(WEIGHT);
                  if (s > 255) begin m_cur = 255; m_sat = 1; end
                  else m_cur = s;
               end
               if (m_cnt < 255) m_cnt++;
            end else begin
               m_cur = dec;
            end
            m_arr = a;
         end else begin
            m_arr = 0;
            m_sat = 0;
         end
         hist.push_front(spike_in);
         if (hist.size() > 40) void'(hist.pop_back());
      end
      @(posedge clk);
      #1;
      chk("current", current, m_cur);
      chk("arrived", arrived, m_arr);
      chk("saturated", saturated, m_sat);
      chk("spike_count", spike_count, m_cnt);
      log_cur.push_back(int'(current));
      log_arr.push_back(int'(arrived));
      log_sat.push_back(int'(saturated));
      log_cnt.push_back(int'(spike_count));
   endtask

   task automatic find_arr(input int from, output int idx);
      idx = -1;
      for (int j = from; j < log_arr.size(); j++) begin
         if (log_arr[j] == 1) begin
            idx = j;
            break;
         end
      end
      if (idx < 0) begin
         chk("arrive_timeout", 0, 1);
         idx = from;
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0; spike_in = 1'b0;
      step();
      rst_n = 1'b1;
   endtask

   initial begin
      int mark, i, frozen_cur, frozen_cnt;
      int exp_seq[8];
      clk = 1'b0;
      rst_n = 1'b0; spike_in = 1'b1; enable = 1'b1;
      WEIGHT = 8'd0; INHIBIT = 1'b0; DECAY_SHIFT = 3'd0; DELAY = 4'd0;

      // reset held 2 cycles with spike high
      step(); step();
      chk("rst_current", current, 0);
      chk("rst_arrived", arrived, 0);
      chk("rst_saturated", saturated, 0);
      chk("rst_count", spike_count, 0);

      // single spike decay, k=1, spike on first edge after release
      rst_n = 1'b1; WEIGHT = 8'd100; DECAY_SHIFT = 3'd1; INHIBIT = 1'b0;
      mark = log_cur.size();
      spike_in = 1'b1; step();
      spike_in = 1'b0;
      for (int j = 0; j < 12; j++) step();
      find_arr(mark, i);
      chk("first_latency", i - mark, LAT0);
      chk("decay_start", log_cur[i], 100);
      exp_seq = '{50, 25, 13, 7, 4, 2, 1, 0};
      for (int j = 0; j < 8; j++) chk("decay_seq", log_cur[i+1+j], exp_seq[j]);
      chk("arrived_once", log_arr[i+1], 0);

      // three back-to-back excitatory spikes saturating
      do_reset();
      WEIGHT = 8'd200; DECAY_SHIFT = 3'd7;
      mark = log_cur.size();
      spike_in = 1'b1; step(); step(); step();
      spike_in = 1'b0;
      for (int j = 0; j < 5; j++) step();
      find_arr(mark, i);
      chk("sat_c0", log_cur[i], 200);
      chk("sat_s0", log_sat[i], 0);
      chk("sat_c1", log_cur[i+1], 255);
      chk("sat_s1", log_sat[i+1], 1);
      chk("sat_c2", log_cur[i+2], 255);
      chk("sat_s2", log_sat[i+2], 1);
      chk("sat_arr2", log_arr[i+2], 1);
      chk("sat_cnt", log_cnt[i+2], 3);

      // current 30 then inhibitory 50 clamps to 0
      do_reset();
      DECAY_SHIFT = 3'd7;
      mark = log_cur.size();
      for (int j = 0; j < 5; j++) begin
         spike_in = (j < 2);
         if (j - LAT0 == 0) begin WEIGHT = 8'd30; INHIBIT = 1'b0; end
         else if (j - LAT0 == 1) begin WEIGHT = 8'd50; INHIBIT = 1'b1; end
         step();
      end
      find_arr(mark, i);
      chk("inh_c0", log_cur[i], 30);
      chk("inh_c1", log_cur[i+1], 0);
      chk("inh_s1", log_sat[i+1], 1);
      INHIBIT = 1'b0;

      // enable low while a spike arrives: frozen state, spike dropped
      do_reset();
      WEIGHT = 8'd80; DECAY_SHIFT = 3'd7;
      spike_in = 1'b1; step();
      spike_in = 1'b0; step(); step();
      frozen_cur = m_cur; frozen_cnt = m_cnt;
      chk("pre_dis_cnt", spike_count, 1);
      enable = 1'b0;
      spike_in = 1'b1; step();
      spike_in = 1'b0;
      for (int j = 0; j < 4; j++) begin
         step();
         chk("dis_cur", current, frozen_cur);
         chk("dis_cnt", spike_count, frozen_cnt);
      end
      enable = 1'b1;
      step(); step();

`ifdef SYN_DELAY_EN
      // tap latency: DELAY=5 -> 6 edges, DELAY=0 -> 1 edge
      do_reset();
      DELAY = 4'd5; step(); step();
      mark = log_cur.size();
      spike_in = 1'b1; step();
      spike_in = 1'b0;
      for (int j = 0; j < 10; j++) step();
      find_arr(mark, i);
      chk("delay5_lat", i - mark, 6);
      DELAY = 4'd0; step();
      mark = log_cur.size();
      spike_in = 1'b1; step();
      spike_in = 1'b0;
      for (int j = 0; j < 4; j++) step();
      find_arr(mark, i);
      chk("delay0_lat", i - mark, 1);
`endif

      // randomized traffic against the model
      for (int j = 0; j < 500; j++) begin
         rst_n       = ($urandom_range(0, 99) != 0);
         spike_in    = ($urandom_range(0, 9) < 4);
         enable      = ($urandom_range(0, 9) != 0);
         WEIGHT      = 8'($urandom_range(0, 255));
         INHIBIT     = ($urandom_range(0, 3) == 0);
         DECAY_SHIFT = 3'($urandom_range(0, 7));
         if ($urandom_range(0, 49) == 0) DELAY = 4'($urandom_range(0, 15));
         step();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
      $finish;
   end

endmodule

// File: doc/spike_synapse.md
# spike_synapse

Receives the 1-bit spike train produced by a leaky integrate-and-fire neuron and converts it into the 8-bit `current` drive for a downstream neuron. Each arriving spike adds an excitatory weight to, or subtracts an inhibitory weight from, a decaying synaptic current register. An optional programmable axonal delay line sits between `spike_in` and the integrator. It is the spike-consuming end of the neuron-to-neuron link in the SNN datapath.

## Interface
Parameters:
- `DELAY_DEPTH`, default 16: number of delay-line stages; `DELAY` may select taps 0..DELAY_DEPTH-1.

Ports:
- `clk` in 1: single clock; everything updates on its rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `spike_in` in 1: spike from the upstream neuron; any high cycle is one spike.
- `enable` in 1: when low, the decay and integration logic holds its value. The delay line keeps shifting.
- `WEIGHT` in 8: unsigned synaptic weight applied per spike.
- `INHIBIT` in 1: 0 means the weight is added; 1 means it is subtracted.
- `DECAY_SHIFT` in 3: decay rate, k, of the current register.
- `DELAY` in 4: axonal delay in cycles. Used only when `SYN_DELAY_EN` is defined.
- `current` out 8: synaptic current, registered; feeds the next neuron's current input.
- `arrived` out 1: registered one-cycle pulse marking the edge where a spike was integrated.
- `saturated` out 1: registered. High for one cycle when an add clamped at 255 or a subtract clamped at 0.
- `spike_count` out 8: count of integrated spikes, saturating at 255.

## Operation
Reset:
- Applied on any edge where `rst_n` is 0.
- `current` = 0, `arrived` = 0, `saturated` = 0, `spike_count` = 0, and all delay stages cleared.
- Reset overrides every other input, including a spike or arrival on the same edge.

Decay is computed every enabled edge, before integration:
- `d = current >> k`.
- If `d == 0` and `current != 0`, then `d = 1`. This guarantees decay reaches 0.
- `k = 0` gives d = current, so the register clears each cycle and the block acts as a pure pulse synapse.
- `decayed = current - d`.

Integration, using a 9-bit intermediate:
- On arrival with `INHIBIT` = 0: `next = decayed + WEIGHT`. If the result is above 255, clamp to 255 and pulse `saturated`.
- On arrival with `INHIBIT` = 1: if `decayed < WEIGHT`, `next` = 0 and `saturated` pulses. Otherwise `next = decayed - WEIGHT`.
- With no arrival: `next = decayed`.

Outputs on an enabled edge:
- `arrived` = arrival.
- `spike_count` increments on arrival and holds at 255.

With `enable` = 0:
- `current` and `spike_count` hold their values.
- `arrived` and `saturated` are driven 0.
- An arrival occurring while disabled is dropped; it is not queued.

`WEIGHT` = 0 with an arrival:
- `current` = `decayed`.
- `arrived` still pulses and the count increments.

`WEIGHT`, `INHIBIT` and `DECAY_SHIFT` are sampled on the same edge as the arrival they apply to.

## Timing
- Edge k is the first rising edge at which `spike_in` = 1 is sampled.
- With the delay line, `current`, `arrived` and `spike_count` reflect that spike after edge k+1+DELAY.
- Without the delay line, they reflect it after edge k.
- Consecutive spikes are each integrated independently, one per cycle, with no merging.
- Spikes separated by one cycle stay separated by one cycle after the delay.
- Changing `DELAY` moves the tap immediately. Spikes already in the line keep their stage positions, so they can be skipped or re-seen once; this behaviour is specified and is not an error.
- Releasing reset: the first spike sampled on the first edge with `rst_n` = 1 follows the normal latency.

## Configuration
`SYN_DELAY_EN`:
- Defined: a `DELAY_DEPTH`-bit shift register sits on `spike_in` and the arrival is stage[`DELAY`]. If `DELAY` ≥ `DELAY_DEPTH`, the last stage is used.
- Undefined: arrival = `spike_in` directly, the `DELAY` port is ignored, and no delay storage is built.

## Test plan
- Reset with `rst_n` = 0 for 2 cycles while `spike_in` = 1 -> all outputs 0; no arrival for spikes sampled during reset.
- `WEIGHT` = 100, k = 1, `INHIBIT` = 0, delay disabled, a single spike -> `current` = 100, then 50, 25, 13, 7, 4, 2, 1, 0 on successive edges; `arrived` pulses once.
- `WEIGHT` = 200, spikes on 3 consecutive cycles, k = 7 -> `current` goes 200, then 255 with `saturated` high, then 255 with `saturated` high; `spike_count` = 3.
- `current` = 30 with k = 7 (decays to 29), then an inhibitory spike with `WEIGHT` = 50 -> `current` = 0 and `saturated` pulses.
- `SYN_DELAY_EN` defined, `DELAY` = 5, spike sampled at edge 10 -> `arrived` high only after edge 16; `DELAY` = 0 gives edge 11.
- `enable` = 0 during an arrival -> `current` frozen at its prior value, the spike is lost and `spike_count` is unchanged.
